// File: rtl/register_file.sv
// Writeback stage of the in-order pipeline: WB pipeline register, 32x64 GPR file
// and the machine-mode CSR set, with combinational register reads.
module register_file (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_to_wb_valid,
    input  logic [315:0] mem_to_wb_bus,
    input  logic         mem_flush,
    output logic         wb_allowin,
    input  logic [4:0]   raddr1,
    input  logic [4:0]   raddr2,
    output logic [63:0]  rdata1,
    output logic [63:0]  rdata2,
    output logic         wb_valid,
    output logic [31:0]  wb_pc,
    output logic [4:0]   wb_rd,
    output logic         wb_reg_wen,
    output logic [63:0]  wb_reg_wdata,
    output logic         wb_csr_we,
    output logic [63:0]  wb_csrwdata,
    output logic [63:0]  wb_csrrdata,
    output logic         wb_mret,
    output logic         wb_ebreak,
    output logic         wb_memwrite,
    output logic [63:0]  wb_diff_addr,
    output logic [63:0]  wb_diff_data,
    output logic [63:0]  csr_mepc,
    output logic [63:0]  csr_mtvec,
    output logic [63:0]  csr_mstatus,
    output logic [63:0]  csr_mcause,
    output logic [63:0]  csr_mie,
    output logic [63:0]  csr_mip,
    output logic [63:0]  csr_mscratch,
    output logic [63:0]  csr_mhartid
);

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;
    localparam logic [63:0] MSTATUS_RST  = 64'h0000_000A_0000_1800;

    // mret: MIE <= MPIE, MPIE <= 1, MPP <= M-mode, everything else kept
    function automatic logic [63:0] mret_mstatus(input logic [63:0] s);
        logic [63:0] r;
        r       = s;
        r[3]    = s[7];
        r[7]    = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    logic         wb_valid_q, wb_valid_d;
    logic [315:0] bus_q, bus_d;
    logic [63:0]  gpr_q [0:31];
    logic [63:0]  gpr_d [0:31];
    logic [63:0]  mstatus_q, mstatus_d;
    logic [63:0]  mie_q, mie_d;
    logic [63:0]  mtvec_q, mtvec_d;
    logic [63:0]  mscratch_q, mscratch_d;
    logic [63:0]  mepc_q, mepc_d;
    logic [63:0]  mcause_q, mcause_d;
    logic [63:0]  mip_q, mip_d;

    logic [63:0]  result_s;
    logic         reg_wen_raw_s;
    logic         mret_raw_s;
    logic         csr_we_raw_s;
    logic [11:0]  csr_addr_s;
    logic [63:0]  csr_wdata_s;
    logic [63:0]  csr_rdata_s;
    logic         gpr_we_s;
    logic         unused_bus_bits_s;

    assign result_s      = bus_q[63:0];
    assign reg_wen_raw_s = bus_q[69];
    assign mret_raw_s    = bus_q[109];
    assign csr_we_raw_s  = bus_q[110];
    assign csr_addr_s    = bus_q[122:111];
    assign csr_wdata_s   = bus_q[186:123];
    assign unused_bus_bits_s = ^{bus_q[315], bus_q[108:104]};

    assign wb_allowin   = 1'b1;
    assign wb_valid     = wb_valid_q;
    assign wb_pc        = bus_q[101:70];
    assign wb_rd        = bus_q[68:64];
    assign wb_diff_addr = bus_q[250:187];
    assign wb_diff_data = bus_q[314:251];
    assign wb_reg_wen   = reg_wen_raw_s & wb_valid_q;
    assign wb_ebreak    = bus_q[102] & wb_valid_q;
    assign wb_memwrite  = bus_q[103] & wb_valid_q;
    assign wb_mret      = mret_raw_s & wb_valid_q;
    assign wb_csr_we    = csr_we_raw_s & wb_valid_q;
    assign wb_csrwdata  = csr_wdata_s;
    assign wb_csrrdata  = csr_rdata_s;
    assign wb_reg_wdata = csr_we_raw_s ? csr_rdata_s : result_s;
    assign gpr_we_s     = wb_reg_wen & (wb_rd != 5'd0);

    assign csr_mstatus  = mstatus_q;
    assign csr_mie      = mie_q;
    assign csr_mtvec    = mtvec_q;
    assign csr_mscratch = mscratch_q;
    assign csr_mepc     = mepc_q;
    assign csr_mcause   = mcause_q;
    assign csr_mip      = mip_q;
    assign csr_mhartid  = 64'd0;

    // Register reads are combinational; forwarding of wb_reg_wdata happens outside.
    assign rdata1 = (raddr1 == 5'd0) ? 64'd0 : gpr_q[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 64'd0 : gpr_q[raddr2];

    // CSR read mux on the latched address
    always_comb begin
        csr_rdata_s = 64'd0;
        case (csr_addr_s)
            CSR_MSTATUS:  csr_rdata_s = mstatus_q;
            CSR_MIE:      csr_rdata_s = mie_q;
            CSR_MTVEC:    csr_rdata_s = mtvec_q;
            CSR_MSCRATCH: csr_rdata_s = mscratch_q;
            CSR_MEPC:     csr_rdata_s = mepc_q;
            CSR_MCAUSE:   csr_rdata_s = mcause_q;
            CSR_MIP:      csr_rdata_s = mip_q;
            CSR_MHARTID:  csr_rdata_s = 64'd0;
            default:      csr_rdata_s = 64'd0;
        endcase
    end

    // WB pipeline register next state: bus is captured on valid even when flushed
    always_comb begin
        wb_valid_d = mem_to_wb_valid & ~mem_flush;
        if (mem_to_wb_valid) begin
            bus_d = mem_to_wb_bus;
        end else begin
            bus_d = bus_q;
        end
    end

    // CSR next state; an explicit CSR write to mstatus wins over mret
    always_comb begin
        mie_d      = (wb_csr_we && csr_addr_s == CSR_MIE)      ? csr_wdata_s : mie_q;
        mtvec_d    = (wb_csr_we && csr_addr_s == CSR_MTVEC)    ? csr_wdata_s : mtvec_q;
        mscratch_d = (wb_csr_we && csr_addr_s == CSR_MSCRATCH) ? csr_wdata_s : mscratch_q;
        mepc_d     = (wb_csr_we && csr_addr_s == CSR_MEPC)     ? csr_wdata_s : mepc_q;
        mcause_d   = (wb_csr_we && csr_addr_s == CSR_MCAUSE)   ? csr_wdata_s : mcause_q;
        mip_d      = (wb_csr_we && csr_addr_s == CSR_MIP)      ? csr_wdata_s : mip_q;
        if (wb_csr_we && csr_addr_s == CSR_MSTATUS) begin
            mstatus_d = csr_wdata_s;
        end else if (wb_mret) begin
            mstatus_d = mret_mstatus(mstatus_q);
        end else begin
            mstatus_d = mstatus_q;
        end
    end

    // GPR next state; x0 is never written
    always_comb begin
        gpr_d = gpr_q;
        if (gpr_we_s) begin
            gpr_d[wb_rd] = wb_reg_wdata;
        end else begin
            gpr_d = gpr_q;
        end
    end

    // WB register and CSR state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q <= 1'b0;
            bus_q      <= 316'd0;
            mstatus_q  <= MSTATUS_RST;
            mie_q      <= 64'd0;
            mtvec_q    <= 64'd0;
            mscratch_q <= 64'd0;
            mepc_q     <= 64'd0;
            mcause_q   <= 64'd0;
            mip_q      <= 64'd0;
        end else begin
            wb_valid_q <= wb_valid_d;
            bus_q      <= bus_d;
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mip_q      <= mip_d;
        end
    end

    // General-purpose register array
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= 64'd0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against a field-level
// architectural model of the writeback stage, GPRs and CSRs.
module tb_register_file;

    logic         clk;
    logic         rst;
    logic         mem_to_wb_valid;
    logic [315:0] mem_to_wb_bus;
    logic         mem_flush;
    logic         wb_allowin;
    logic [4:0]   raddr1, raddr2;
    logic [63:0]  rdata1, rdata2;
    logic         wb_valid, wb_reg_wen, wb_csr_we, wb_mret, wb_ebreak, wb_memwrite;
    logic [31:0]  wb_pc;
    logic [4:0]   wb_rd;
    logic [63:0]  wb_reg_wdata, wb_csrwdata, wb_csrrdata, wb_diff_addr, wb_diff_data;
    logic [63:0]  csr_mepc, csr_mtvec, csr_mstatus, csr_mcause;
    logic [63:0]  csr_mie, csr_mip, csr_mscratch, csr_mhartid;

    int n_cmp = 0;
    int n_err = 0;

    register_file dut (
        .clk(clk), .rst(rst),
        .mem_to_wb_valid(mem_to_wb_valid), .mem_to_wb_bus(mem_to_wb_bus),
        .mem_flush(mem_flush), .wb_allowin(wb_allowin),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_reg_wen(wb_reg_wen),
        .wb_reg_wdata(wb_reg_wdata), .wb_csr_we(wb_csr_we), .wb_csrwdata(wb_csrwdata),
        .wb_csrrdata(wb_csrrdata), .wb_mret(wb_mret), .wb_ebreak(wb_ebreak),
        .wb_memwrite(wb_memwrite), .wb_diff_addr(wb_diff_addr), .wb_diff_data(wb_diff_data),
        .csr_mepc(csr_mepc), .csr_mtvec(csr_mtvec), .csr_mstatus(csr_mstatus),
        .csr_mcause(csr_mcause), .csr_mie(csr_mie), .csr_mip(csr_mip),
        .csr_mscratch(csr_mscratch), .csr_mhartid(csr_mhartid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [63:0]  m_gpr [0:31];
    logic [63:0]  m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mip;
    logic         m_valid;
    logic [315:0] m_bus;

    function automatic logic [315:0] pack(
        input logic [63:0] result, input logic [4:0] rd, input logic reg_wen,
        input logic [31:0] pc, input logic ebreak, input logic memwrite,
        input logic mret, input logic csr_we, input logic [11:0] csr_addr,
        input logic [63:0] csr_wdata, input logic [63:0] diff_addr,
        input logic [63:0] diff_data);
        logic [315:0] b;
        b = 316'd0;
        b[63:0]    = result;
        b[68:64]   = rd;
        b[69]      = reg_wen;
        b[101:70]  = pc;
        b[102]     = ebreak;
        b[103]     = memwrite;
        b[109]     = mret;
        b[110]     = csr_we;
        b[122:111] = csr_addr;
        b[186:123] = csr_wdata;
        b[250:187] = diff_addr;
        b[314:251] = diff_data;
        return b;
    endfunction

    function automatic logic [63:0] m_csr_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip;
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = 64'd0;
        m_mstatus = 64'h0000_000A_0000_1800;
        m_mie = 64'd0; m_mtvec = 64'd0; m_mscratch = 64'd0; m_mepc = 64'd0;
        m_mcause = 64'd0; m_mip = 64'd0;
        m_valid = 1'b0;
        m_bus = 316'd0;
    endtask

    // Retire the instruction held in WB, then accept the incoming bus
    task automatic model_edge();
        logic [63:0] wdata, old_ms;
        logic [11:0] a;
        logic        cwe;
        if (m_valid) begin
            a = m_bus[122:111];
            cwe = m_bus[110];
            wdata = cwe ? m_csr_read(a) : m_bus[63:0];
            if (m_bus[69] && m_bus[68:64] != 5'd0) m_gpr[m_bus[68:64]] = wdata;
            old_ms = m_mstatus;
            if (cwe) begin
                case (a)
                    12'h300: m_mstatus  = m_bus[186:123];
                    12'h304: m_mie      = m_bus[186:123];
                    12'h305: m_mtvec    = m_bus[186:123];
                    12'h340: m_mscratch = m_bus[186:123];
                    12'h341: m_mepc     = m_bus[186:123];
                    12'h342: m_mcause   = m_bus[186:123];
                    12'h344: m_mip      = m_bus[186:123];
                    default: ;
                endcase
            end
            if (m_bus[109] && !(cwe && a == 12'h300))
                m_mstatus = (old_ms & ~64'h8) | (((old_ms >> 7) & 64'd1) << 3)
                            | 64'h80 | 64'h1800;
        end
        m_valid = mem_to_wb_valid & ~mem_flush;
        if (mem_to_wb_valid) m_bus = mem_to_wb_bus;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic v;
        v = m_valid;
        chk({tag, ".allowin"},  {63'd0, wb_allowin}, 64'd1);
        chk({tag, ".valid"},    {63'd0, wb_valid}, {63'd0, v});
        chk({tag, ".pc"},       {32'd0, wb_pc}, {32'd0, m_bus[101:70]});
        chk({tag, ".rd"},       {59'd0, wb_rd}, {59'd0, m_bus[68:64]});
        chk({tag, ".reg_wen"},  {63'd0, wb_reg_wen}, {63'd0, m_bus[69] & v});
        chk({tag, ".csr_we"},   {63'd0, wb_csr_we}, {63'd0, m_bus[110] & v});
        chk({tag, ".mret"},     {63'd0, wb_mret}, {63'd0, m_bus[109] & v});
        chk({tag, ".ebreak"},   {63'd0, wb_ebreak}, {63'd0, m_bus[102] & v});
        chk({tag, ".memwrite"}, {63'd0, wb_memwrite}, {63'd0, m_bus[103] & v});
        chk({tag, ".csrrdata"}, wb_csrrdata, m_csr_read(m_bus[122:111]));
        chk({tag, ".csrwdata"}, wb_csrwdata, m_bus[186:123]);
        chk({tag, ".reg_wdata"}, wb_reg_wdata,
            m_bus[110] ? m_csr_read(m_bus[122:111]) : m_bus[63:0]);
        chk({tag, ".diff_addr"}, wb_diff_addr, m_bus[250:187]);
        chk({tag, ".diff_data"}, wb_diff_data, m_bus[314:251]);
        chk({tag, ".rdata1"}, rdata1, m_gpr[raddr1]);
        chk({tag, ".rdata2"}, rdata2, m_gpr[raddr2]);
        chk({tag, ".mstatus"},  csr_mstatus, m_mstatus);
        chk({tag, ".mie"},      csr_mie, m_mie);
        chk({tag, ".mtvec"},    csr_mtvec, m_mtvec);
        chk({tag, ".mscratch"}, csr_mscratch, m_mscratch);
        chk({tag, ".mepc"},     csr_mepc, m_mepc);
        chk({tag, ".mcause"},   csr_mcause, m_mcause);
        chk({tag, ".mip"},      csr_mip, m_mip);
        chk({tag, ".mhartid"},  csr_mhartid, 64'd0);
    endtask

    task automatic drive(input logic v, input logic f, input logic [315:0] b,
                         input logic [4:0] r1, input logic [4:0] r2);
        mem_to_wb_valid = v;
        mem_flush = f;
        mem_to_wb_bus = b;
        raddr1 = r1;
        raddr2 = r2;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    function automatic logic [11:0] pick_csr();
        int k;
        k = $urandom_range(0, 9);
        case (k)
            0: return 12'h300;
            1: return 12'h304;
            2: return 12'h305;
            3: return 12'h340;
            4: return 12'h341;
            5: return 12'h342;
            6: return 12'h344;
            7: return 12'hF14;
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    initial begin
        logic [315:0] b;
        rst = 1'b0;
        drive(1'b0, 1'b0, 316'd0, 5'd0, 5'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        raddr1 = 5'd5;
        #1;
        chk("reset.rdata_x5", rdata1, 64'd0);
        chk("reset.mstatus", csr_mstatus, 64'h0000_000A_0000_1800);
        rst = 1'b1;

        // basic GPR write then read
        drive(1'b1, 1'b0, pack(64'h1234, 5'd5, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0,
              1'b0, 12'h000, 64'd0, 64'h10, 64'h20), 5'd0, 5'd0);
        tick("wr_x5");
        chk("wr_x5.valid", {63'd0, wb_valid}, 64'd1);
        chk("wr_x5.wdata", wb_reg_wdata, 64'h1234);
        drive(1'b0, 1'b0, 316'd0, 5'd5, 5'd0);
        tick("rd_x5");
        chk("rd_x5.rdata1", rdata1, 64'h1234);

        // x0 discards writes
        drive(1'b1, 1'b0, pack(64'hFFFF, 5'd0, 1'b1, 32'h8000_0004, 1'b0, 1'b0, 1'b0,
              1'b0, 12'h000, 64'd0, 64'd0, 64'd0), 5'd0, 5'd0);
        tick("wr_x0");
        drive(1'b0, 1'b0, 316'd0, 5'd0, 5'd0);
        tick("rd_x0");
        chk("rd_x0.rdata1", rdata1, 64'd0);

        // CSR write to mepc returns the old value into rd
        drive(1'b1, 1'b0, pack(64'h55, 5'd3, 1'b1, 32'h8000_0008, 1'b0, 1'b0, 1'b0,
              1'b1, 12'h341, 64'h8000_0010, 64'd0, 64'd0), 5'd0, 5'd0);
        tick("csrw_mepc");
        chk("csrw_mepc.wdata", wb_reg_wdata, 64'd0);
        drive(1'b0, 1'b0, 316'd0, 5'd3, 5'd0);
        tick("csrw_mepc2");
        chk("csrw_mepc.mepc", csr_mepc, 64'h8000_0010);
        chk("csrw_mepc.x3", rdata1, 64'd0);

        // mret from a known mstatus
        drive(1'b1, 1'b0, pack(64'd0, 5'd0, 1'b0, 32'h8000_000C, 1'b0, 1'b0, 1'b0,
              1'b1, 12'h300, 64'h0000_000A_0000_0080, 64'd0, 64'd0), 5'd0, 5'd0);
        tick("set_ms");
        drive(1'b1, 1'b0, pack(64'd0, 5'd0, 1'b0, 32'h8000_0010, 1'b0, 1'b0, 1'b1,
              1'b0, 12'h000, 64'd0, 64'd0, 64'd0), 5'd0, 5'd0);
        tick("mret");
        drive(1'b0, 1'b0, 316'd0, 5'd0, 5'd0);
        tick("mret2");
        chk("mret.mstatus", csr_mstatus, 64'h0000_000A_0000_1888);

        // flushed instruction does not retire
        drive(1'b1, 1'b0, pack(64'hAAAA, 5'd7, 1'b1, 32'h8000_0014, 1'b0, 1'b0, 1'b0,
              1'b0, 12'h000, 64'd0, 64'd0, 64'd0), 5'd0, 5'd0);
        tick("wr_x7");
        drive(1'b1, 1'b1, pack(64'hBBBB, 5'd7, 1'b1, 32'h8000_0018, 1'b0, 1'b0, 1'b0,
              1'b0, 12'h000, 64'd0, 64'd0, 64'd0), 5'd0, 5'd0);
        tick("flush");
        chk("flush.valid", {63'd0, wb_valid}, 64'd0);
        drive(1'b0, 1'b0, 316'd0, 5'd7, 5'd0);
        tick("flush2");
        chk("flush.x7", rdata1, 64'hAAAA);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            b = pack({$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                     $urandom, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), pick_csr(),
                     {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), b,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            tick("rand");
        end

        // asynchronous reset mid-stream discards the pending write
        drive(1'b1, 1'b0, pack(64'hDEAD, 5'd9, 1'b1, 32'h8000_0100, 1'b0, 1'b0, 1'b0,
              1'b0, 12'h000, 64'd0, 64'd0, 64'd0), 5'd9, 5'd5);
        @(posedge clk);
        model_edge();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst.valid", {63'd0, wb_valid}, 64'd0);
        chk("arst.rdata2", rdata2, 64'd0);
        chk("arst.mstatus", csr_mstatus, 64'h0000_000A_0000_1800);
        @(posedge clk);
        #1;
        check_all("arst_hold");
        drive(1'b0, 1'b0, 316'd0, 5'd9, 5'd7);
        rst = 1'b1;
        tick("arst_rel");
        chk("arst.x9", rdata1, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-low reset.
REQ-002 SHALL have these pipeline ports: mem_to_wb_valid input 1; mem_to_wb_bus input 316; mem_flush input 1; wb_allowin output 1.
REQ-003 SHALL have these register-read ports: raddr1 input 5; raddr2 input 5; rdata1 output 64; rdata2 output 64.
REQ-004 SHALL have these writeback outputs: wb_valid 1; wb_pc 32; wb_rd 5; wb_reg_wen 1; wb_reg_wdata 64; wb_csr_we 1; wb_csrwdata 64; wb_csrrdata 64; wb_mret 1; wb_ebreak 1; wb_memwrite 1; wb_diff_addr 64; wb_diff_data 64.
REQ-005 SHALL output csr_mepc, csr_mtvec, csr_mstatus, csr_mcause, csr_mie, csr_mip, csr_mscratch and csr_mhartid, each 64 bits, as the live CSR values.
REQ-006 SHALL decode mem_to_wb_bus as follows: [63:0] result; [68:64] rd; [69] reg_wen; [101:70] pc; [102] ebreak; [103] memwrite; [108:104] reserved, driven 0; [109] mret; [110] csr_we; [122:111] csr_addr; [186:123] csr_wdata; [250:187] diff_addr; [314:251] diff_data; [315] reserved.

Function
REQ-007 SHALL tie wb_allowin to 1, because WB always has ready_go = 1.
REQ-008 SHALL, on each clk edge, set wb_valid <= mem_to_wb_valid & ~mem_flush.
REQ-009 SHALL latch the bus into the WB register whenever mem_to_wb_valid = 1; with mem_to_wb_valid = 0 the WB register holds its contents.
REQ-010 SHALL gate wb_reg_wen, wb_csr_we, wb_mret, wb_ebreak and wb_memwrite with wb_valid.
REQ-011 SHALL drive wb_pc, wb_rd, wb_diff_addr and wb_diff_data directly from the WB register, ungated.
REQ-012 SHALL implement 32 x 64-bit GPRs; x0 always reads 0 and writes to it are discarded.
REQ-013 SHALL read rdata1/rdata2 combinationally from raddr1/raddr2, with no internal write-through bypass (forwarding is done externally using wb_reg_wdata).
REQ-014 SHALL set wb_reg_wdata = wb_csrrdata when the latched csr_we = 1, and the latched result otherwise.
REQ-015 SHALL write gpr[wb_rd] <= wb_reg_wdata on the clk edge when wb_reg_wen = 1 and wb_rd != 0; a value is therefore readable on rdata the cycle after wb_valid.
REQ-016 SHALL compute wb_csrrdata combinationally from csr_addr: 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x344 mip, 0xF14 mhartid; any other address reads 0.
REQ-017 SHALL drive wb_csrwdata directly from the latched csr_wdata.
REQ-018 SHALL, on the edge with wb_csr_we = 1, write csr_wdata to the addressed CSR; writes to mhartid or to an unmapped address are ignored.
REQ-019 SHALL, on the edge with wb_mret = 1, update mstatus as MIE[3] <= MPIE[7], MPIE <= 1, MPP[12:11] <= 2'b11, with all other fields unchanged.
REQ-020 SHALL give the CSR write priority over mret when both are set in the same cycle; mret is applied afterwards on mstatus only if the CSR write did not target mstatus.
REQ-021 SHALL leave the mepc value untouched by mret; the external fetch logic redirects to csr_mepc.
REQ-022 SHALL take exactly one cycle from bus acceptance to the WB outputs, with no stall condition.

Reset
REQ-023 SHALL, while rst = 0 (asynchronous), force wb_valid = 0 and all GPRs = 0.
REQ-024 SHALL reset mstatus to 0x0000000A00001800 and mepc, mtvec, mcause, mie, mip, mscratch to 0.
REQ-025 SHALL reset the WB register to 0, so wb_pc = 0 and all gated strobes = 0.
REQ-026 SHALL drive csr_mhartid = 0 permanently.
REQ-027 SHALL, when reset is asserted mid-operation, discard any pending write.

Verification
REQ-028 SHALL pass this scenario: write rd=5, result=0x1234, reg_wen=1, valid=1 -> next cycle wb_valid=1, wb_reg_wdata=0x1234; the cycle after, raddr1=5 gives rdata1=0x1234.
REQ-029 SHALL pass this scenario: rd=0, reg_wen=1, result=0xFFFF -> rdata for x0 stays 0.
REQ-030 SHALL pass this scenario: csr_we=1, csr_addr=0x341, csr_wdata=0x80000010, rd=3, with mepc previously 0 -> wb_reg_wdata=0, then csr_mepc=0x80000010 and x3=0.
REQ-031 SHALL pass this scenario: mret=1 with mstatus=0xA00000080 -> mstatus=0xA00001888.
REQ-032 SHALL pass this scenario: mem_to_wb_valid=1 and mem_flush=1 with reg_wen=1 -> wb_valid=0 and no GPR change.
REQ-033 SHALL pass this scenario: assert rst=0 mid-stream -> wb_valid=0 immediately, GPRs=0, mstatus=0xA00001800.
